// File: rtl/fc_layer_engine.sv
// Fully-connected layer sequencer: LANES neurons per pass, streamed activations and
// lane-wide weight words, per-lane accumulation, shift/saturate/optional-ReLU writeback.
module fc_layer_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int N_IN   = 784,
  parameter int N_OUT  = 200,
  parameter int LANES  = 8,
  parameter int IN_AW  = 10,
  parameter int W_AW   = 15,
  parameter int OUT_AW = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  output logic [IN_AW-1:0]          in_addr,
  input  logic [DATA_W-1:0]         in_data,
  output logic [W_AW-1:0]           w_addr,
  input  logic [LANES*DATA_W-1:0]   w_data,
  output logic                      out_we,
  output logic [OUT_AW-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                   state;
  logic                     relu_q;
  logic                     valid_q;
  logic [LW-1:0]            lane;
  logic [OUT_AW-1:0]        nbase;
  logic signed [ACC_W-1:0]  acc  [LANES];
  logic signed [2*DATA_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        res;
  logic                     last_k;
  logic                     last_lane;
  logic                     last_group;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i] = $signed(in_data) * $signed(w_data[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    shifted = acc[lane] >>> FRAC;
    if (shifted > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                        res = shifted[DATA_W-1:0];
    if (relu_q && res[DATA_W-1]) res = '0;
  end

  // nbase is g*LANES; the tail group stops at neuron N_OUT-1 instead of lane LANES-1.
  assign last_k     = (in_addr == IN_AW'(N_IN - 1));
  assign last_lane  = (lane == LW'(LANES - 1)) ||
                      (32'(nbase) + 32'(lane) + 32'd1 == 32'(N_OUT));
  assign last_group = (32'(nbase) + 32'(LANES) >= 32'(N_OUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      relu_q   <= 1'b0;
      valid_q  <= 1'b0;
      lane     <= '0;
      nbase    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_addr  <= '0;
      w_addr   <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      out_we  <= 1'b0;
      done    <= 1'b0;
      valid_q <= (state == S_FETCH);
      if (valid_q) begin
        for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc[i] + ACC_W'(prod[i]);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            busy    <= 1'b1;
            relu_q  <= relu_en;
            in_addr <= '0;
            w_addr  <= '0;
            nbase   <= '0;
            lane    <= '0;
            for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
          end
        end
        S_FETCH: begin
          // Addresses hold on the last k so the next group starts at w_addr+1.
          if (last_k) begin
            state <= S_DRAIN;
          end else begin
            in_addr <= in_addr + IN_AW'(1);
            w_addr  <= w_addr + W_AW'(1);
          end
        end
        S_DRAIN: begin
          state <= S_WRITE;
          lane  <= '0;
        end
        S_WRITE: begin
          out_we   <= 1'b1;
          out_addr <= nbase + OUT_AW'(lane);
          out_data <= res;
          if (last_lane) begin
            lane <= '0;
            if (last_group) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              nbase   <= nbase + OUT_AW'(LANES);
              in_addr <= '0;
              w_addr  <= w_addr + W_AW'(1);
              for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
            end
          end else begin
            lane <= lane + LW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed scoreboard bench for fc_layer_engine with a small layer (4 in, 3 out, 2 lanes).
module tb_fc_layer_engine;

  localparam int DW = 16;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int LN = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            relu_en;
  logic            busy;
  logic            done;
  logic [2:0]      in_addr;
  logic [DW-1:0]   in_data;
  logic [3:0]      w_addr;
  logic [LN*DW-1:0] w_data;
  logic            out_we;
  logic [2:0]      out_addr;
  logic [DW-1:0]   out_data;

  logic signed [DW-1:0] in_v [NI];
  logic signed [DW-1:0] wt   [NO][NI];

  typedef struct {
    logic [2:0]    a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int done_cnt = 0;
  bit sb_on = 1'b0;

  fc_layer_engine #(
    .DATA_W(16), .FRAC(8), .ACC_W(40), .N_IN(NI), .N_OUT(NO), .LANES(LN),
    .IN_AW(3), .W_AW(4), .OUT_AW(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM models; lanes past the last neuron return junk.
  always @(posedge clk) begin
    in_data <= (int'(in_addr) < NI) ? in_v[in_addr] : 16'h0000;
    for (int l = 0; l < LN; l++) begin
      int j, k;
      j = (int'(w_addr) / NI) * LN + l;
      k = int'(w_addr) % NI;
      w_data[l*DW +: DW] <= (j < NO) ? wt[j][k] : 16'h7FFF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_we) begin
      writes++;
      if (sb_on) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_write observed addr=%0d data=%h expected none", out_addr, out_data);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          assert (out_addr === e.a) else begin
            failures++;
            $error("FAIL wr_addr observed=%0d expected=%0d", out_addr, e.a);
          end
          checks++;
          assert (out_data === e.d) else begin
            failures++;
            $error("FAIL wr_data@%0d observed=%h expected=%h", e.a, out_data, e.d);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] model(input int j, input bit relu);
    longint s = 0;
    for (int k = 0; k < NI; k++) s += longint'(in_v[k]) * longint'(wt[j][k]);
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return DW'(s);
  endfunction

  task automatic push_expected(input bit relu);
    exp_t x;
    for (int j = 0; j < NO; j++) begin
      x.a = 3'(j);
      x.d = model(j, relu);
      sb.push_back(x);
    end
  endtask

  task automatic set_all(input logic [DW-1:0] iv, input logic [DW-1:0] wv);
    for (int k = 0; k < NI; k++) begin
      in_v[k] = iv;
      for (int j = 0; j < NO; j++) wt[j][k] = wv;
    end
  endtask

  task automatic run(input bit relu, input bit glitch, input bit chk_addr, input string tag);
    int lat, bn, w0, d0;
    push_expected(relu);
    sb_on = 1'b1;
    w0 = writes;
    d0 = done_cnt;
    lat = 0;
    bn = 0;
    @(negedge clk);
    start = 1'b1;
    relu_en = relu;
    @(negedge clk);
    start = 1'b0;
    relu_en = ~relu;
    for (int n = 1; n <= 200; n++) begin
      if (glitch) start = (n == 2);
      if (chk_addr && n >= 1 && n <= 4) begin
        check({tag, "_w_addr_g0"}, 32'(w_addr), 32'(n - 1));
        check({tag, "_in_addr_g0"}, 32'(in_addr), 32'(n - 1));
      end
      if (chk_addr && n >= 8 && n <= 11) begin
        check({tag, "_w_addr_g1"}, 32'(w_addr), 32'(4 + n - 8));
        check({tag, "_in_addr_g1"}, 32'(in_addr), 32'(n - 8));
      end
      if (busy) bn++;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_latency"}, 32'(lat), 32'd14);
    check({tag, "_busy_cycles"}, 32'(bn), 32'd13);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 32'(done), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_write_count"}, 32'(writes - w0), 32'd3);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, w0, d1, d2, bn, seen;
    reset = 1'b1;
    start = 1'b0;
    relu_en = 1'b0;
    set_all(16'h0100, 16'h0100);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_in_addr", 32'(in_addr), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Unit data and weights.
    run(1'b0, 1'b0, 1'b0, "t1_unit");

    // Negative lane-0 weights, identity then ReLU.
    set_all(16'h0100, 16'h0100);
    for (int k = 0; k < NI; k++) begin
      wt[0][k] = 16'shFF00;
      wt[2][k] = 16'shFF00;
    end
    run(1'b0, 1'b0, 1'b0, "t2_neg_ident");
    run(1'b1, 1'b0, 1'b0, "t2_neg_relu");

    // Saturation both ways.
    set_all(16'h7FFF, 16'h7FFF);
    run(1'b0, 1'b0, 1'b0, "t3_sat_pos");
    set_all(16'h7FFF, 16'h8000);
    run(1'b0, 1'b0, 1'b0, "t3_sat_neg");

    // Distinct inputs and per-neuron weights, with address sequence.
    for (int k = 0; k < NI; k++) begin
      in_v[k] = DW'((k + 1) * 256);
      for (int j = 0; j < NO; j++) wt[j][k] = DW'((j + 1) * 256);
    end
    run(1'b0, 1'b0, 1'b1, "t4_distinct");

    // Start pulsed again mid-FETCH must be ignored.
    run(1'b0, 1'b1, 1'b0, "t5_glitch");

    // Reset during WRITE abandons the layer.
    sb_on = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      if (out_we) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("t5_write_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_out_we", 32'(out_we), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("t5_no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    run(1'b0, 1'b0, 1'b0, "t5_after_rst");

    // Start held high: back-to-back runs separated by one IDLE cycle.
    push_expected(1'b0);
    push_expected(1'b0);
    sb_on = 1'b1;
    d0 = done_cnt;
    w0 = writes;
    d1 = 0;
    d2 = 0;
    bn = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 100; n++) begin
      if (busy) bn++;
      if (done && d1 == 0) d1 = n;
      else if (done) begin
        d2 = n;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("t6_first_done", 32'(d1), 32'd14);
    check("t6_second_done", 32'(d2), 32'd29);
    check("t6_busy_cycles", 32'(bn), 32'd26);
    @(negedge clk);
    check("t6_done_count", 32'(done_cnt - d0), 32'd2);
    check("t6_write_count", 32'(writes - w0), 32'd6);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    repeat (20) @(negedge clk);
    check("t6_no_extra_run", 32'(done_cnt - d0), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
